// File: rtl/vidasic_pkg.sv
// Shared types and widths for the bitstream fetch path.
package vidasic_pkg;
    localparam int QUEUE_W = 48;
    localparam int WORD_W  = 16;
    localparam int ADDR_W  = 25;
    localparam int FILL_W  = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } fetch_state_t;
endpackage

// File: rtl/bit_queue.sv
// MSB-aligned bit queue: consume shifts out the oldest bits, append lands
// the new word directly behind the surviving bits.
module bit_queue
    import vidasic_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              consume_en,
    input  logic [4:0]        consume_len,
    input  logic              append_en,
    input  logic [WORD_W-1:0] append_data,
    output logic [WORD_W-1:0] peek,
    output logic [FILL_W-1:0] fill,
    output logic              underflow
);
    logic [QUEUE_W-1:0] queue;
    logic [QUEUE_W-1:0] shifted;
    logic [QUEUE_W-1:0] word_ext;
    logic [QUEUE_W-1:0] queue_next;
    logic [FILL_W-1:0]  fill_shift;
    logic [FILL_W-1:0]  fill_next;
    logic               legal;

    assign peek = queue[QUEUE_W-1 -: WORD_W];

    always_comb begin
        legal      = consume_en && (consume_len != 5'd0) &&
                     ({1'b0, consume_len} <= fill);
        shifted    = legal ? (queue << consume_len) : queue;
        fill_shift = legal ? (fill - {1'b0, consume_len}) : fill;
        // The shift happens first, so the word is placed after the post-consume fill.
        word_ext   = {append_data, {(QUEUE_W-WORD_W){1'b0}}} >> fill_shift;
        queue_next = append_en ? (shifted | word_ext) : shifted;
        fill_next  = append_en ? (fill_shift + FILL_W'(WORD_W)) : fill_shift;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            queue     <= '0;
            fill      <= '0;
            underflow <= 1'b0;
        end else if (clear) begin
            queue     <= '0;
            fill      <= '0;
            underflow <= 1'b0;
        end else begin
            queue <= queue_next;
            fill  <= fill_next;
            if (consume_en && !legal)
                underflow <= 1'b1;
        end
    end
endmodule

// File: rtl/bitstream_fetch.sv
// SDRAM word fetcher feeding a 48-bit bit queue for the stream decoder.
module bitstream_fetch
    import vidasic_pkg::*;
#(
    parameter logic [ADDR_W-1:0] START_ADDR   = 25'h0000000,
    parameter int                REFILL_LEVEL = 32
) (
    input  logic              clk50,
    input  logic              reset,
    input  logic              run,
    input  logic              restart,
    output logic              ram_rden,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [WORD_W-1:0] ram_data,
    input  logic              ram_ack,
    output logic [WORD_W-1:0] peek_bits,
    output logic [FILL_W-1:0] fill,
    input  logic              consume_en,
    input  logic [4:0]        consume_len,
    output logic              underflow
);
    localparam logic [FILL_W-1:0] REFILL_FILL = FILL_W'(REFILL_LEVEL);

    fetch_state_t      state, state_next;
    logic [ADDR_W-1:0] addr;
    logic              addr_inc;
    logic              capture;

    assign ram_rden = (state == REQ);
    assign ram_addr = addr;
    assign capture  = (state == REQ) && ram_ack && !restart;

    always_comb begin
        state_next = state;
        addr_inc   = 1'b0;
        case (state)
            // Holding off while ack is still high keeps a stale ack (after
            // restart or reset) from being taken as the answer to a new request.
            IDLE: if (!restart && run && !ram_ack && (fill <= REFILL_FILL))
                state_next = REQ;
            REQ: begin
                if (restart)      state_next = IDLE;
                else if (ram_ack) state_next = RELEASE;
            end
            RELEASE: begin
                if (restart) state_next = IDLE;
                else if (!ram_ack) begin
                    state_next = IDLE;
                    addr_inc   = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            addr  <= START_ADDR;
        end else begin
            state <= state_next;
            if (restart)       addr <= START_ADDR;
            else if (addr_inc) addr <= addr + 1'b1;
        end
    end

    bit_queue u_queue (
        .clk         (clk50),
        .rst         (reset),
        .clear       (restart),
        .consume_en  (consume_en),
        .consume_len (consume_len),
        .append_en   (capture),
        .append_data (ram_data),
        .peek        (peek_bits),
        .fill        (fill),
        .underflow   (underflow)
    );
endmodule

// File: tb/tb_bitstream_fetch.sv
// Directed bench for bitstream_fetch: refill, consume, underflow, restart,
// address wrap and reset during an outstanding ack.
module tb_bitstream_fetch;
    logic        clk50 = 1'b0;
    logic        reset, run, restart, ram_ack, consume_en;
    logic [15:0] ram_data;
    logic [4:0]  consume_len;
    logic        ram_rden, underflow;
    logic [24:0] ram_addr;
    logic [15:0] peek_bits;
    logic [5:0]  fill;

    logic        run_b, ack_b;
    logic [15:0] data_b;
    logic        rden_b, uf_b;
    logic [24:0] addr_b;
    logic [15:0] peek_b;
    logic [5:0]  fill_b;

    int total = 0;
    int bad   = 0;

    always #5 clk50 = ~clk50;

    bitstream_fetch dut (
        .clk50(clk50), .reset(reset), .run(run), .restart(restart),
        .ram_rden(ram_rden), .ram_addr(ram_addr), .ram_data(ram_data),
        .ram_ack(ram_ack), .peek_bits(peek_bits), .fill(fill),
        .consume_en(consume_en), .consume_len(consume_len), .underflow(underflow)
    );

    bitstream_fetch #(.START_ADDR(25'h1FFFFFF), .REFILL_LEVEL(32)) dut_b (
        .clk50(clk50), .reset(reset), .run(run_b), .restart(restart),
        .ram_rden(rden_b), .ram_addr(addr_b), .ram_data(data_b),
        .ram_ack(ack_b), .peek_bits(peek_b), .fill(fill_b),
        .consume_en(1'b0), .consume_len(5'd0), .underflow(uf_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk50);
        #1;
    endtask

    task automatic consume(input logic [4:0] len);
        consume_en  = 1'b1;
        consume_len = len;
        step();
        consume_en  = 1'b0;
        consume_len = 5'd0;
    endtask

    // One ack pulse held for three cycles; fill must rise by 16 exactly once.
    task automatic fetch(input logic [15:0] d, input logic [24:0] a, input logic [5:0] f0);
        chk("fetch_rden", 32'(ram_rden), 32'd1);
        chk("fetch_addr", 32'(ram_addr), 32'(a));
        ram_ack  = 1'b1;
        ram_data = d;
        step();
        chk("fetch_fill1", 32'(fill), 32'(f0 + 6'd16));
        chk("fetch_rden_rel", 32'(ram_rden), 32'd0);
        step();
        step();
        chk("fetch_fill3", 32'(fill), 32'(f0 + 6'd16));
        ram_ack = 1'b0;
        step();
        step();
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; restart = 1'b0; ram_ack = 1'b0;
        ram_data = '0; consume_en = 1'b0; consume_len = '0;
        run_b = 1'b0; ack_b = 1'b0; data_b = '0;
        #1;
        chk("rst_fill", 32'(fill), 32'd0);
        chk("rst_peek", 32'(peek_bits), 32'd0);
        chk("rst_rden", 32'(ram_rden), 32'd0);
        chk("rst_addr", 32'(ram_addr), 32'd0);
        chk("rst_uf", 32'(underflow), 32'd0);
        chk("rst_addr_b", 32'(addr_b), 32'h1FFFFFF);
        step(); step();
        reset = 1'b0;
        step();
        chk("idle_norun", 32'(ram_rden), 32'd0);

        run = 1'b1;
        step();
        fetch(16'h3449, 25'd0, 6'd0);
        fetch(16'h7220, 25'd1, 6'd16);
        fetch(16'h13C1, 25'd2, 6'd32);
        chk("full_fill", 32'(fill), 32'd48);
        chk("full_peek", 32'(peek_bits), 32'h3449);
        chk("full_norq", 32'(ram_rden), 32'd0);
        chk("full_addr", 32'(ram_addr), 32'd3);

        consume(5'd4);
        chk("c4_peek", 32'(peek_bits), 32'h4497);
        chk("c4_fill", 32'(fill), 32'd44);
        step();
        chk("c4_norq", 32'(ram_rden), 32'd0);

        consume(5'd12);
        chk("c12_fill", 32'(fill), 32'd32);
        chk("c12_peek", 32'(peek_bits), 32'h7220);
        step();
        chk("c12_rden", 32'(ram_rden), 32'd1);
        chk("c12_addr", 32'(ram_addr), 32'd3);

        // capture and consume of 16 on the same edge
        ram_ack = 1'b1; ram_data = 16'hB0F0;
        consume_en = 1'b1; consume_len = 5'd16;
        step();
        consume_en = 1'b0; consume_len = 5'd0;
        chk("cc_fill", 32'(fill), 32'd32);
        chk("cc_peek", 32'(peek_bits), 32'h13C1);
        run = 1'b0;
        step();
        ram_ack = 1'b0;
        step();
        step();
        chk("stop_rden", 32'(ram_rden), 32'd0);
        chk("stop_addr", 32'(ram_addr), 32'd4);

        consume(5'd16);
        chk("c16_fill", 32'(fill), 32'd16);
        chk("c16_peek", 32'(peek_bits), 32'hB0F0);
        consume(5'd6);
        chk("c6_fill", 32'(fill), 32'd10);
        chk("c6_peek", 32'(peek_bits), 32'h3C00);
        chk("c6_uf", 32'(underflow), 32'd0);
        consume(5'd12);
        chk("ovr_fill", 32'(fill), 32'd10);
        chk("ovr_peek", 32'(peek_bits), 32'h3C00);
        chk("ovr_uf", 32'(underflow), 32'd1);
        step();
        chk("ovr_uf_hold", 32'(underflow), 32'd1);
        consume(5'd0);
        chk("zero_fill", 32'(fill), 32'd10);

        restart = 1'b1;
        step();
        restart = 1'b0;
        chk("rs_uf", 32'(underflow), 32'd0);
        chk("rs_fill", 32'(fill), 32'd0);
        chk("rs_peek", 32'(peek_bits), 32'd0);
        chk("rs_addr", 32'(ram_addr), 32'd0);

        // reset while in RELEASE with ack still high
        run = 1'b1;
        step();
        chk("r38_rden", 32'(ram_rden), 32'd1);
        ram_ack = 1'b1; ram_data = 16'h1234;
        step();
        chk("r38_fill", 32'(fill), 32'd16);
        #3;
        reset = 1'b1;
        #1;
        chk("r38_async_rden", 32'(ram_rden), 32'd0);
        chk("r38_async_fill", 32'(fill), 32'd0);
        chk("r38_async_peek", 32'(peek_bits), 32'd0);
        step();
        reset = 1'b0;
        step(); step(); step();
        chk("stale_fill", 32'(fill), 32'd0);
        chk("stale_rden", 32'(ram_rden), 32'd0);
        ram_ack = 1'b0;
        step();
        chk("post_rden", 32'(ram_rden), 32'd1);
        chk("post_addr", 32'(ram_addr), 32'd0);
        run = 1'b0;

        // address wrap on the second instance, run dropped during REQ
        run_b = 1'b1;
        step();
        chk("b_rden", 32'(rden_b), 32'd1);
        chk("b_addr", 32'(addr_b), 32'h1FFFFFF);
        run_b = 1'b0;
        step();
        chk("b_hold_rden", 32'(rden_b), 32'd1);
        ack_b = 1'b1; data_b = 16'hABCD;
        step();
        chk("b_fill", 32'(fill_b), 32'd16);
        ack_b = 1'b0;
        step();
        chk("b_wrap", 32'(addr_b), 32'd0);
        step(); step();
        chk("b_norq", 32'(rden_b), 32'd0);
        chk("b_peek", 32'(peek_b), 32'hABCD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
